// File: rtl/pc_sequencer_pkg.sv
// Shared architecture defines for the fetch front end: instruction type
// codes seen by the program-counter sequencer and its next-PC select encoding.
package pc_sequencer_pkg;

  typedef logic [4:0] instr_code_t;

  localparam instr_code_t INSTR_NOP   = 5'h00;
  localparam instr_code_t INSTR_ALU   = 5'h01;
  localparam instr_code_t INSTR_LOAD  = 5'h02;
  localparam instr_code_t INSTR_STORE = 5'h03;
  localparam instr_code_t INSTR_JUMP  = 5'h08;
  localparam instr_code_t INSTR_CALL  = 5'h09;
  localparam instr_code_t INSTR_RET   = 5'h0A;

  // Source selected for the next PC value.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_JUMP,
    SEL_RET,
    SEL_REDIRECT
  } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/execute <-> PC sequencer bus: instruction, redirect and fetch address.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  instr_valid;
  instr_code_t           current_instruction_type;
  logic [DATA_WIDTH-1:0] jump_condition;
  logic [ADDR_WIDTH-1:0] jump_address;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_address;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_redirected;

  modport master (
    output stall, instr_valid, current_instruction_type, jump_condition,
           jump_address, redirect_valid, redirect_address,
    input  pc, pc_redirected
  );

  modport slave (
    input  stall, instr_valid, current_instruction_type, jump_condition,
           jump_address, redirect_valid, redirect_address,
    output pc, pc_redirected
  );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack. top_ptr indexes the most recent entry; a
// push on a full stack silently overwrites the oldest slot, so the newest
// RAS_DEPTH return addresses always survive.
module return_stack #(
  parameter int  ADDR_WIDTH = 32,
  parameter int  RAS_DEPTH  = 8,
  localparam int PTR_W      = $clog2(RAS_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top_data,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow_evt
);

  logic [ADDR_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]      top_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  do_pop;

  assign wr_ptr       = top_ptr + PTR_W'(1);
  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(RAS_DEPTH));
  assign do_pop       = pop && !push && !empty;
  assign overflow_evt = push && full;
  assign top_data     = mem[top_ptr];

  // Pointer and occupancy; the count saturates at RAS_DEPTH on overwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push) begin
      top_ptr <= wr_ptr;
      if (!full) count <= count + CNT_W'(1);
    end else if (do_pop) begin
      top_ptr <= top_ptr - PTR_W'(1);
      count   <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter: next-PC mux with redirect/stall priority,
// conditional jumps, call/return through the return stack, sticky RAS flags.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                   ADDR_WIDTH   = 32,
  parameter int                   DATA_WIDTH   = 32,
  parameter int                   INSTR_BYTES  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                   RAS_DEPTH    = 8,
  localparam int                  CNT_WIDTH    = $clog2(RAS_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pc_sequencer_if.slave        bus,
  input  logic                 clear_flags,
  output logic [CNT_WIDTH-1:0] ras_count,
  output logic                 ras_overflow,
  output logic                 ras_underflow
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] seq;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic                  redir_q;
  logic                  next_redir;
  logic                  push;
  logic                  pop;
  logic                  ras_empty;
  logic                  ras_full;
  logic                  ras_ovf_evt;
  logic                  ovf_set;
  logic                  unf_set;
  pc_sel_e               sel;

  assign seq               = pc_q + ADDR_WIDTH'(INSTR_BYTES);
  assign ovf_set           = ras_ovf_evt && ras_full;
  assign bus.pc            = pc_q;
  assign bus.pc_redirected = redir_q;

  return_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAS_DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .pop          (pop),
    .push_data    (seq),
    .top_data     (ras_top),
    .count        (ras_count),
    .empty        (ras_empty),
    .full         (ras_full),
    .overflow_evt (ras_ovf_evt)
  );

  // Decision: redirect beats stall, stall freezes everything else.
  always_comb begin
    sel        = SEL_HOLD;
    next_redir = redir_q;
    push       = 1'b0;
    pop        = 1'b0;
    unf_set    = 1'b0;
    if (bus.redirect_valid) begin
      sel        = SEL_REDIRECT;
      next_redir = 1'b1;
    end else if (!bus.stall) begin
      if (!bus.instr_valid) begin
        next_redir = 1'b0;
      end else begin
        unique case (bus.current_instruction_type)
          INSTR_JUMP: begin
            if (bus.jump_condition == DATA_WIDTH'(1)) begin
              sel        = SEL_JUMP;
              next_redir = 1'b1;
            end else begin
              sel        = SEL_SEQ;
              next_redir = 1'b0;
            end
          end
          INSTR_CALL: begin
            push       = 1'b1;
            sel        = SEL_JUMP;
            next_redir = 1'b1;
          end
          INSTR_RET: begin
            if (!ras_empty) begin
              pop        = 1'b1;
              sel        = SEL_RET;
              next_redir = 1'b1;
            end else begin
              sel        = SEL_SEQ;
              unf_set    = 1'b1;
              next_redir = 1'b0;
            end
          end
          default: begin
            sel        = SEL_SEQ;
            next_redir = 1'b0;
          end
        endcase
      end
    end
  end

  // Next-PC mux; targets pass through unaligned.
  always_comb begin
    next_pc = pc_q;
    unique case (sel)
      SEL_HOLD:     next_pc = pc_q;
      SEL_SEQ:      next_pc = seq;
      SEL_JUMP:     next_pc = bus.jump_address;
      SEL_RET:      next_pc = ras_top;
      SEL_REDIRECT: next_pc = bus.redirect_address;
      default:      next_pc = pc_q;
    endcase
  end

  // PC register and redirect indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      redir_q <= 1'b0;
    end else begin
      pc_q    <= next_pc;
      redir_q <= next_redir;
    end
  end

  // Sticky RAS flags; a same-cycle set overrides clear_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_overflow  <= ovf_set || (ras_overflow && !clear_flags);
      ras_underflow <= unf_set || (ras_underflow && !clear_flags);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios on a depth-8 and a depth-2
// instance, then random traffic against a behavioural stack model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        iv = 1'b0;
  instr_code_t itype = INSTR_NOP;
  logic [31:0] jcond = '0;
  logic [31:0] jaddr = '0;
  logic        rvalid = 1'b0;
  logic [31:0] raddr = '0;
  logic        clr = 1'b0;

  logic [3:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic        ovf_a, unf_a, ovf_b, unf_b;

  int checks = 0;
  int errors = 0;

  // Reference model state: [0] = depth-8 instance, [1] = depth-2 instance.
  logic [31:0] m_pc    [2];
  logic        m_redir [2];
  logic        m_ovf   [2];
  logic        m_unf   [2];
  int          m_cnt   [2];
  logic [31:0] m_stk   [2][8];

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
  pc_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

  assign bus_a.stall = stall;
  assign bus_a.instr_valid = iv;
  assign bus_a.current_instruction_type = itype;
  assign bus_a.jump_condition = jcond;
  assign bus_a.jump_address = jaddr;
  assign bus_a.redirect_valid = rvalid;
  assign bus_a.redirect_address = raddr;
  assign bus_b.stall = stall;
  assign bus_b.instr_valid = iv;
  assign bus_b.current_instruction_type = itype;
  assign bus_b.jump_condition = jcond;
  assign bus_b.jump_address = jaddr;
  assign bus_b.redirect_valid = rvalid;
  assign bus_b.redirect_address = raddr;

  pc_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INSTR_BYTES(4),
                 .RESET_VECTOR(RV), .RAS_DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .clear_flags(clr),
    .ras_count(cnt_a), .ras_overflow(ovf_a), .ras_underflow(unf_a));

  pc_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INSTR_BYTES(4),
                 .RESET_VECTOR(RV), .RAS_DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .clear_flags(clr),
    .ras_count(cnt_b), .ras_overflow(ovf_b), .ras_underflow(unf_b));

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = RV; m_redir[i] = 1'b0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  // One clock of architectural behaviour: the stack is a plain array whose
  // oldest entry shifts out when a call arrives on a full stack.
  task automatic model_step(input int id, input int depth);
    logic [31:0] seq;
    logic        oset, uset;
    seq = m_pc[id] + 32'd4;
    oset = 1'b0; uset = 1'b0;
    if (rvalid) begin
      m_pc[id] = raddr; m_redir[id] = 1'b1;
    end else if (stall) begin
    end else if (!iv) begin
      m_redir[id] = 1'b0;
    end else if (itype == INSTR_JUMP) begin
      if (jcond == 32'd1) begin m_pc[id] = jaddr; m_redir[id] = 1'b1; end
      else begin m_pc[id] = seq; m_redir[id] = 1'b0; end
    end else if (itype == INSTR_CALL) begin
      if (m_cnt[id] == depth) begin
        oset = 1'b1;
        for (int k = 0; k < depth - 1; k++) m_stk[id][k] = m_stk[id][k+1];
        m_stk[id][depth-1] = seq;
      end else begin
        m_stk[id][m_cnt[id]] = seq;
        m_cnt[id]++;
      end
      m_pc[id] = jaddr; m_redir[id] = 1'b1;
    end else if (itype == INSTR_RET) begin
      if (m_cnt[id] > 0) begin
        m_cnt[id]--;
        m_pc[id] = m_stk[id][m_cnt[id]]; m_redir[id] = 1'b1;
      end else begin
        m_pc[id] = seq; uset = 1'b1; m_redir[id] = 1'b0;
      end
    end else begin
      m_pc[id] = seq; m_redir[id] = 1'b0;
    end
    m_ovf[id] = oset | (m_ovf[id] & ~clr);
    m_unf[id] = uset | (m_unf[id] & ~clr);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0, 8);
    model_step(1, 2);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; iv = 1'b0; rvalid = 1'b0; clr = 1'b0; itype = INSTR_NOP;
  endtask

  task automatic go_to(input logic [31:0] a);
    idle(); rvalid = 1'b1; raddr = a; cyc(); rvalid = 1'b0;
  endtask

  task automatic issue(input instr_code_t t, input logic [31:0] target);
    idle(); iv = 1'b1; itype = t; jaddr = target; jcond = 32'd1; cyc(); idle();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0; model_reset(); #2; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus_a.pc !== RV || bus_a.pc_redirected !== 1'b0 || cnt_a !== 4'd0 ||
        ovf_a !== 1'b0 || unf_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h redir=%b cnt=%0d ovf=%b unf=%b exp pc=%h 0 0 0 0",
               bus_a.pc, bus_a.pc_redirected, cnt_a, ovf_a, unf_a, RV);
    end
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      idle(); iv = 1'b1; itype = INSTR_ALU; cyc();
      checks++;
      if (bus_a.pc !== RV + 32'(4 * i) || bus_a.pc_redirected !== 1'b0) begin
        errors++;
        $display("FAIL reset_seq%0d pc=%h redir=%b exp %h 0", i, bus_a.pc,
                 bus_a.pc_redirected, RV + 32'(4 * i));
      end
    end
    idle();
  endtask

  task automatic test_jump();
    logic [31:0] conds [3];
    logic [31:0] exp_pc;
    conds[0] = 32'd1; conds[1] = 32'd2; conds[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      go_to(32'h10);
      idle(); iv = 1'b1; itype = INSTR_JUMP; jaddr = 32'h80; jcond = conds[i]; cyc();
      exp_pc = (i == 0) ? 32'h80 : 32'h14;
      checks++;
      if (bus_a.pc !== exp_pc || bus_a.pc_redirected !== (i == 0)) begin
        errors++;
        $display("FAIL jump_cond%0d pc=%h redir=%b exp %h %b", i, bus_a.pc,
                 bus_a.pc_redirected, exp_pc, (i == 0));
      end
      idle(); cyc();
      checks++;
      if (bus_a.pc !== exp_pc || bus_a.pc_redirected !== 1'b0) begin
        errors++;
        $display("FAIL jump_after%0d pc=%h redir=%b exp %h 0", i, bus_a.pc,
                 bus_a.pc_redirected, exp_pc);
      end
    end
  endtask

  task automatic test_call_ret();
    logic [31:0] exp_pc [6];
    int          exp_cnt [6];
    instr_code_t ops [6];
    logic [31:0] tgt [6];
    go_to(32'h20);
    issue(INSTR_CALL, 32'h200);
    checks++;
    if (bus_a.pc !== 32'h200 || cnt_a !== 4'd1) begin
      errors++; $display("FAIL call pc=%h cnt=%0d exp 200 1", bus_a.pc, cnt_a);
    end
    issue(INSTR_RET, 32'h0);
    checks++;
    if (bus_a.pc !== 32'h24 || cnt_a !== 4'd0 || bus_a.pc_redirected !== 1'b1) begin
      errors++; $display("FAIL ret pc=%h cnt=%0d redir=%b exp 24 0 1", bus_a.pc, cnt_a,
                         bus_a.pc_redirected);
    end
    ops = '{INSTR_CALL, INSTR_ALU, INSTR_CALL, INSTR_RET, INSTR_RET, INSTR_ALU};
    tgt = '{32'h200, 32'h0, 32'h300, 32'h0, 32'h0, 32'h0};
    exp_pc = '{32'h200, 32'h204, 32'h300, 32'h208, 32'h24, 32'h28};
    exp_cnt = '{1, 1, 2, 1, 0, 0};
    go_to(32'h20);
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], tgt[i]);
      checks++;
      if (bus_a.pc !== exp_pc[i] || cnt_a !== 4'(exp_cnt[i])) begin
        errors++; $display("FAIL nested%0d pc=%h cnt=%0d exp %h %0d", i, bus_a.pc, cnt_a,
                           exp_pc[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_overflow();
    reset_pulse();
    go_to(32'h10);
    issue(INSTR_CALL, 32'h20);
    issue(INSTR_CALL, 32'h30);
    checks++;
    if (ovf_b !== 1'b0 || cnt_b !== 2'd2) begin
      errors++; $display("FAIL ovf_pre ovf=%b cnt=%0d exp 0 2", ovf_b, cnt_b);
    end
    issue(INSTR_CALL, 32'h40);
    checks++;
    if (ovf_b !== 1'b1 || cnt_b !== 2'd2 || bus_b.pc !== 32'h40) begin
      errors++; $display("FAIL ovf_set ovf=%b cnt=%0d pc=%h exp 1 2 40", ovf_b, cnt_b, bus_b.pc);
    end
    issue(INSTR_RET, 32'h0);
    checks++;
    if (bus_b.pc !== 32'h34 || cnt_b !== 2'd1) begin
      errors++; $display("FAIL ovf_ret1 pc=%h cnt=%0d exp 34 1", bus_b.pc, cnt_b);
    end
    issue(INSTR_RET, 32'h0);
    checks++;
    if (bus_b.pc !== 32'h24 || cnt_b !== 2'd0) begin
      errors++; $display("FAIL ovf_ret2 pc=%h cnt=%0d exp 24 0", bus_b.pc, cnt_b);
    end
    issue(INSTR_RET, 32'h0);
    checks++;
    if (bus_b.pc !== 32'h28 || unf_b !== 1'b1 || cnt_b !== 2'd0 ||
        bus_b.pc_redirected !== 1'b0 || ovf_b !== 1'b1) begin
      errors++; $display("FAIL underflow pc=%h unf=%b cnt=%0d redir=%b ovf=%b exp 28 1 0 0 1",
                         bus_b.pc, unf_b, cnt_b, bus_b.pc_redirected, ovf_b);
    end
    idle(); clr = 1'b1; cyc(); idle();
    checks++;
    if (ovf_b !== 1'b0 || unf_b !== 1'b0) begin
      errors++; $display("FAIL clear_flags ovf=%b unf=%b exp 0 0", ovf_b, unf_b);
    end
    idle(); iv = 1'b1; itype = INSTR_RET; clr = 1'b1; cyc(); idle();
    checks++;
    if (unf_b !== 1'b1) begin
      errors++; $display("FAIL set_wins unf=%b exp 1", unf_b);
    end
    idle(); clr = 1'b1; cyc(); idle();
  endtask

  task automatic test_interactions();
    reset_pulse();
    go_to(32'h50);
    idle(); stall = 1'b1; iv = 1'b1; itype = INSTR_CALL; jaddr = 32'h500;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (bus_a.pc !== 32'h50 || cnt_a !== 4'd0 || bus_a.pc_redirected !== 1'b1) begin
        errors++; $display("FAIL stall%0d pc=%h cnt=%0d redir=%b exp 50 0 1", i, bus_a.pc,
                           cnt_a, bus_a.pc_redirected);
      end
    end
    stall = 1'b0; cyc(); idle();
    checks++;
    if (bus_a.pc !== 32'h500 || cnt_a !== 4'd1) begin
      errors++; $display("FAIL stall_release pc=%h cnt=%0d exp 500 1", bus_a.pc, cnt_a);
    end
    idle(); stall = 1'b1; rvalid = 1'b1; raddr = 32'h400; cyc(); idle();
    checks++;
    if (bus_a.pc !== 32'h400 || bus_a.pc_redirected !== 1'b1) begin
      errors++; $display("FAIL redirect_stall pc=%h redir=%b exp 400 1", bus_a.pc,
                         bus_a.pc_redirected);
    end
    issue(INSTR_ALU, 32'h0);
    idle(); iv = 1'b1; itype = INSTR_RET; rvalid = 1'b1; raddr = 32'h400; cyc(); idle();
    checks++;
    if (bus_a.pc !== 32'h400 || cnt_a !== 4'd1) begin
      errors++; $display("FAIL redirect_ret pc=%h cnt=%0d exp 400 1", bus_a.pc, cnt_a);
    end
  endtask

  task automatic test_wrap_reset();
    reset_pulse();
    go_to(32'hFFFF_FFFC);
    issue(INSTR_ALU, 32'h0);
    checks++;
    if (bus_a.pc !== 32'h0) begin
      errors++; $display("FAIL wrap pc=%h exp 00000000", bus_a.pc);
    end
    for (int i = 1; i <= 3; i++) issue(INSTR_CALL, 32'(i) << 12);
    checks++;
    if (cnt_a !== 4'd3) begin
      errors++; $display("FAIL calls3 cnt=%0d exp 3", cnt_a);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus_a.pc !== RV || cnt_a !== 4'd0) begin
      errors++; $display("FAIL async_reset pc=%h cnt=%0d exp %h 0", bus_a.pc, cnt_a, RV);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    reset_pulse();
    for (int n = 0; n < 400; n++) begin
      rvalid = ($urandom_range(0, 15) == 0);
      raddr  = $urandom;
      stall  = ($urandom_range(0, 7) == 0);
      iv     = ($urandom_range(0, 3) != 0);
      clr    = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0: itype = INSTR_JUMP;
        1, 2: itype = INSTR_CALL;
        3, 4: itype = INSTR_RET;
        default: itype = instr_code_t'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 4))
        0: jcond = 32'd0;
        1: jcond = 32'd1;
        2: jcond = 32'd2;
        3: jcond = 32'hFFFF_FFFF;
        default: jcond = $urandom;
      endcase
      jaddr = $urandom;
      cyc();
      checks++;
      if (bus_a.pc !== m_pc[0] || bus_a.pc_redirected !== m_redir[0]) begin
        errors++; $display("FAIL rnd_a_pc n=%0d pc=%h redir=%b exp %h %b", n, bus_a.pc,
                           bus_a.pc_redirected, m_pc[0], m_redir[0]);
      end
      checks++;
      if (cnt_a !== 4'(m_cnt[0]) || ovf_a !== m_ovf[0] || unf_a !== m_unf[0]) begin
        errors++; $display("FAIL rnd_a_ras n=%0d cnt=%0d ovf=%b unf=%b exp %0d %b %b", n,
                           cnt_a, ovf_a, unf_a, m_cnt[0], m_ovf[0], m_unf[0]);
      end
      checks++;
      if (bus_b.pc !== m_pc[1] || bus_b.pc_redirected !== m_redir[1]) begin
        errors++; $display("FAIL rnd_b_pc n=%0d pc=%h redir=%b exp %h %b", n, bus_b.pc,
                           bus_b.pc_redirected, m_pc[1], m_redir[1]);
      end
      checks++;
      if (cnt_b !== 2'(m_cnt[1]) || ovf_b !== m_ovf[1] || unf_b !== m_unf[1]) begin
        errors++; $display("FAIL rnd_b_ras n=%0d cnt=%0d ovf=%b unf=%b exp %0d %b %b", n,
                           cnt_b, ovf_b, unf_b, m_cnt[1], m_ovf[1], m_unf[1]);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_jump();
    test_call_ret();
    test_overflow();
    test_interactions();
    test_wrap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
